// File: rtl/sp_ram_march_bist.sv
// -----------------------------------------------------------------------------
// sp_ram_march_bist
//
// March self-test sequencer for a single-port RAM with a registered address.
// It drives the RAM's address, write enable and write data, and checks the read
// data. The test has four phases:
//   W0 : ascending write of the background word
//   R0 : ascending read-compare against the background word
//   W1 : descending write of the inverted background word
//   R1 : descending read-compare against the inverted word
// Each read phase ends with one drain cycle, so the last compare finishes
// before the next phase starts.
//
// Ports
//   clk        : clock shared with the RAM
//   rst        : synchronous, active-high reset
//   start      : launch a test (sampled only when idle or done)
//   abort      : cancel a running test; has priority over start
//   pattern    : background word, captured when start is accepted
//   ram_addr   : RAM address (registered)
//   ram_we     : RAM write enable (registered)
//   ram_wdata  : RAM write data (registered)
//   ram_q      : RAM read data, valid one cycle after its address
//   busy       : test running
//   done       : test finished; held until the next accepted start
//   pass       : done with no mismatches
//   err_count  : total mismatching words
//   fail_addr  : address of the first mismatch
//   fail_phase : phase of the first mismatch (0 = R0, 1 = R1)
// -----------------------------------------------------------------------------
module sp_ram_march_bist #(
   parameter int DATA_WIDTH = 8,
   parameter int ADDR_WIDTH = 6
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [DATA_WIDTH-1:0] pattern,
   output logic [ADDR_WIDTH-1:0] ram_addr,
   output logic                  ram_we,
   output logic [DATA_WIDTH-1:0] ram_wdata,
   input  logic [DATA_WIDTH-1:0] ram_q,
   output logic                  busy,
   output logic                  done,
   output logic                  pass,
   output logic [ADDR_WIDTH+1:0] err_count,
   output logic [ADDR_WIDTH-1:0] fail_addr,
   output logic                  fail_phase
);

   typedef enum logic [2:0] {IDLE, W0, R0, W1, R1, DONE} state_t;

   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   state_t                  state;
   logic [DATA_WIDTH-1:0]   pat_q;
   logic                    drain;      // read phase is in its trailing drain cycle

   // One-stage compare pipeline: the address was presented last cycle and
   // ram_q now carries its data.
   logic                    cmp_valid;
   logic [DATA_WIDTH-1:0]   cmp_exp;
   logic [ADDR_WIDTH-1:0]   cmp_addr;
   logic                    cmp_phase;

   logic                    mismatch;
   logic [ADDR_WIDTH+1:0]   err_next;

   always_comb begin
      mismatch = cmp_valid && (ram_q != cmp_exp);
      err_next = err_count + (ADDR_WIDTH+2)'(mismatch);
   end

   // NOTE: all state here is updated with non-blocking assignments so every
   // register samples the pre-edge values of the others, matching hardware.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= IDLE;
         pat_q      <= '0;
         drain      <= 1'b0;
         cmp_valid  <= 1'b0;
         cmp_exp    <= '0;
         cmp_addr   <= '0;
         cmp_phase  <= 1'b0;
         ram_addr   <= '0;
         ram_we     <= 1'b0;
         ram_wdata  <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         pass       <= 1'b0;
         err_count  <= '0;
         fail_addr  <= '0;
         fail_phase <= 1'b0;
      end else begin
         // NOTE: a compare is only valid for the one cycle after a read
         // address; clear it by default and re-arm it from the read states.
         cmp_valid <= 1'b0;

         if (busy && abort) begin
            // Error results are kept; the in-flight compare is dropped.
            state  <= IDLE;
            drain  <= 1'b0;
            ram_we <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            pass   <= 1'b0;
         end else begin
            if (mismatch) begin
               err_count <= err_next;
               if (err_count == '0) begin
                  fail_addr  <= cmp_addr;
                  fail_phase <= cmp_phase;
               end
            end

            case (state)
               IDLE, DONE: begin
                  if (start) begin
                     state      <= W0;
                     pat_q      <= pattern;
                     err_count  <= '0;
                     fail_addr  <= '0;
                     fail_phase <= 1'b0;
                     done       <= 1'b0;
                     pass       <= 1'b0;
                     busy       <= 1'b1;
                     ram_addr   <= '0;
                     ram_we     <= 1'b1;
                     ram_wdata  <= pattern;
                  end
               end

               W0: begin
                  if (ram_addr == LAST_ADDR) begin
                     state    <= R0;
                     ram_addr <= '0;
                     ram_we   <= 1'b0;
                  end else begin
                     ram_addr <= ram_addr + 1'b1;
                  end
               end

               R0: begin
                  if (drain) begin
                     drain     <= 1'b0;
                     state     <= W1;
                     ram_addr  <= LAST_ADDR;
                     ram_we    <= 1'b1;
                     ram_wdata <= ~pat_q;
                  end else begin
                     cmp_valid <= 1'b1;
                     cmp_addr  <= ram_addr;
                     cmp_exp   <= pat_q;
                     cmp_phase <= 1'b0;
                     // Hold the last address during the drain cycle.
                     if (ram_addr == LAST_ADDR) drain    <= 1'b1;
                     else                       ram_addr <= ram_addr + 1'b1;
                  end
               end

               W1: begin
                  if (ram_addr == '0) begin
                     state    <= R1;
                     ram_addr <= LAST_ADDR;
                     ram_we   <= 1'b0;
                  end else begin
                     ram_addr <= ram_addr - 1'b1;
                  end
               end

               R1: begin
                  if (drain) begin
                     drain <= 1'b0;
                     state <= DONE;
                     busy  <= 1'b0;
                     done  <= 1'b1;
                     // The final compare resolves on this same edge.
                     pass  <= (err_next == '0);
                  end else begin
                     cmp_valid <= 1'b1;
                     cmp_addr  <= ram_addr;
                     cmp_exp   <= ~pat_q;
                     cmp_phase <= 1'b1;
                     if (ram_addr == '0) drain    <= 1'b1;
                     else                ram_addr <= ram_addr - 1'b1;
                  end
               end

               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sp_ram_march_bist.sv
// -----------------------------------------------------------------------------
// tb_sp_ram_march_bist
//
// Bench for sp_ram_march_bist with a registered-address RAM that can inject
// faults. A cycle-indexed model predicts every output from the run's cycle
// number and the injected fault; directed scenarios add literal expectations.
// -----------------------------------------------------------------------------
module tb_sp_ram_march_bist;

   localparam int DW = 8;
   localparam int AW = 6;
   localparam int N  = 1 << AW;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic          abort;
   logic [DW-1:0] pattern;
   logic [AW-1:0] ram_addr;
   logic          ram_we;
   logic [DW-1:0] ram_wdata;
   logic [DW-1:0] ram_q;
   logic          busy;
   logic          done;
   logic          pass;
   logic [AW+1:0] err_count;
   logic [AW-1:0] fail_addr;
   logic          fail_phase;

   int n_cmp  = 0;
   int n_fail = 0;

   // 0 = good RAM, 1 = bit0 stuck at 1 at address 10, 2 = read data tied to 0
   int mode = 0;

   always #5 clk = ~clk;

   sp_ram_march_bist #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .pattern    (pattern),
      .ram_addr   (ram_addr),
      .ram_we     (ram_we),
      .ram_wdata  (ram_wdata),
      .ram_q      (ram_q),
      .busy       (busy),
      .done       (done),
      .pass       (pass),
      .err_count  (err_count),
      .fail_addr  (fail_addr),
      .fail_phase (fail_phase)
   );

   // Registered-address RAM with fault injection on the read path.
   logic [DW-1:0] mem [N];
   logic [AW-1:0] rd_addr;

   always @(posedge clk) begin
      if (ram_we) mem[ram_addr] <= ram_wdata;
      rd_addr <= ram_addr;
   end

   assign ram_q = (mode == 2) ? '0 :
                  (mode == 1 && rd_addr == 10) ? (mem[rd_addr] | 8'h01) :
                  mem[rd_addr];

   function automatic logic [DW-1:0] fault(logic [DW-1:0] d, int a);
      if (mode == 2) return '0;
      if (mode == 1 && a == 10) return d | 8'h01;
      return d;
   endfunction

   task automatic check(string name, int act, int exp);
      n_cmp++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, act, act, exp, exp, $time);
      end
   endtask

   // ---------------------------------------------------------------------------
   // Model: a run is 4N+2 cycles indexed t = 0 .. 4N+1.
   //   W0 [0, N-1]   R0 [N, 2N] (2N = drain)
   //   W1 [2N+1, 3N] R1 [3N+1, 4N+1] (4N+1 = drain)
   // ---------------------------------------------------------------------------
   function automatic bit is_write(int t);
      return (t < N) || (t >= 2*N+1 && t <= 3*N);
   endfunction

   function automatic bit is_read(int t);
      return (t >= N && t <= 2*N-1) || (t >= 3*N+1 && t <= 4*N);
   endfunction

   function automatic int addr_of(int t);
      if (t < N)      return t;
      if (t <= 2*N)   return (t - N > N-1) ? N-1 : t - N;
      if (t <= 3*N)   return 3*N - t;
      return (4*N - t < 0) ? 0 : 4*N - t;
   endfunction

   bit            m_active = 0;
   int            m_t      = 0;
   bit            m_done   = 0;
   bit            m_pass   = 0;
   int            m_err    = 0;
   int            m_faddr  = 0;
   int            m_fphase = 0;
   int            m_hold   = 0;
   logic [DW-1:0] m_pat    = '0;
   logic [DW-1:0] m_mem [N];
   bit            p_valid  = 0;
   int            p_addr   = 0;
   logic [DW-1:0] p_exp    = '0;
   int            p_phase  = 0;

   always @(negedge clk) begin
      int            e_addr;
      bit            e_we;
      logic [DW-1:0] e_wd;
      logic [DW-1:0] q;

      e_we   = m_active && is_write(m_t);
      e_addr = m_active ? addr_of(m_t) : m_hold;
      e_wd   = (m_t < N) ? m_pat : ~m_pat;

      check("busy",       int'(busy),       int'(m_active));
      check("ram_we",     int'(ram_we),     int'(e_we));
      check("ram_addr",   int'(ram_addr),   e_addr);
      if (e_we) check("ram_wdata", int'(ram_wdata), int'(e_wd));
      check("done",       int'(done),       int'(m_done));
      check("pass",       int'(pass),       int'(m_pass));
      check("err_count",  int'(err_count),  m_err);
      check("fail_addr",  int'(fail_addr),  m_faddr);
      check("fail_phase", int'(fail_phase), m_fphase);

      // Advance the model to the next cycle using the inputs sampled at the
      // coming edge.
      if (rst) begin
         m_active = 0; m_t = 0; m_done = 0; m_pass = 0;
         m_err = 0; m_faddr = 0; m_fphase = 0; m_hold = 0; p_valid = 0;
      end else if (m_active && abort) begin
         m_hold   = addr_of(m_t);
         m_active = 0; m_done = 0; m_pass = 0; p_valid = 0;
      end else begin
         if (p_valid) begin
            q = fault(m_mem[p_addr], p_addr);
            if (q != p_exp) begin
               if (m_err == 0) begin
                  m_faddr  = p_addr;
                  m_fphase = p_phase;
               end
               m_err++;
            end
            p_valid = 0;
         end
         if (m_active) begin
            if (is_read(m_t)) begin
               p_valid = 1;
               p_addr  = addr_of(m_t);
               p_exp   = (m_t < 2*N) ? m_pat : ~m_pat;
               p_phase = (m_t < 2*N) ? 0 : 1;
            end
            if (e_we) m_mem[addr_of(m_t)] = e_wd;
            m_hold = addr_of(m_t);
            m_t++;
            if (m_t == 4*N+2) begin
               m_active = 0;
               m_done   = 1;
               m_pass   = (m_err == 0);
            end
         end else if (start) begin
            m_active = 1; m_t = 0; m_pat = pattern;
            m_err = 0; m_faddr = 0; m_fphase = 0; m_done = 0; m_pass = 0;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Directed stimulus; inputs change 1 time unit after each rising edge.
   // ---------------------------------------------------------------------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic run_start(logic [DW-1:0] pat);
      pattern = pat;
      start   = 1'b1;
      tick();
      start   = 1'b0;
   endtask

   task automatic wait_idle(output int n);
      n = 0;
      while (busy && n < 400) begin
         tick();
         n++;
      end
   endtask

   initial begin
      int n;
      rst = 1'b1; start = 1'b0; abort = 1'b0; pattern = '0;
      repeat (2) tick();
      rst = 1'b0;

      check("reset ram_addr",  int'(ram_addr),  0);
      check("reset ram_we",    int'(ram_we),    0);
      check("reset ram_wdata", int'(ram_wdata), 0);
      check("reset busy",      int'(busy),      0);
      check("reset done",      int'(done),      0);
      check("reset err_count", int'(err_count), 0);
      tick();

      // Good RAM, A5.
      mode = 0;
      run_start(8'hA5);
      check("t1 first write we",   int'(ram_we),    1);
      check("t1 first write data", int'(ram_wdata), 8'hA5);
      wait_idle(n);
      check("t1 busy cycles", n, 258);
      check("t1 done",      int'(done),      1);
      check("t1 pass",      int'(pass),      1);
      check("t1 err_count", int'(err_count), 0);
      check("t1 mem[0]",    int'(mem[0]),    8'h5A);
      check("t1 mem[63]",   int'(mem[63]),   8'h5A);
      tick();

      // Bit0 stuck at 1 at address 10: only R1 (expects 5A) fails.
      mode = 1;
      run_start(8'hA5);
      wait_idle(n);
      check("t2 busy cycles", n, 258);
      check("t2 err_count",  int'(err_count),  1);
      check("t2 fail_addr",  int'(fail_addr),  10);
      check("t2 fail_phase", int'(fail_phase), 1);
      check("t2 pass",       int'(pass),       0);
      tick();

      // Read data tied low: every compare fails.
      mode = 2;
      run_start(8'h0F);
      wait_idle(n);
      check("t3 err_count",  int'(err_count),  128);
      check("t3 fail_addr",  int'(fail_addr),  0);
      check("t3 fail_phase", int'(fail_phase), 0);
      check("t3 pass",       int'(pass),       0);
      tick();

      // Abort in R0 with failing reads: counts so far are kept, the pending
      // compare is dropped.
      run_start(8'h0F);
      repeat (100) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t3b busy",      int'(busy),      0);
      check("t3b err_count", int'(err_count), 35);
      tick();
      check("t3b err held",  int'(err_count), 35);

      // Abort on the 5th cycle of W1, then a full clean run.
      mode = 0;
      run_start(8'h3C);
      repeat (2*N+1+4) tick();
      check("t4 in W1 we", int'(ram_we), 1);
      abort = 1'b1;
      tick();
      abort = 1'b0;
      check("t4 abort we",   int'(ram_we), 0);
      check("t4 abort busy", int'(busy),   0);
      check("t4 abort done", int'(done),   0);
      tick();
      run_start(8'hC3);
      wait_idle(n);
      check("t4 rerun cycles", n, 258);
      check("t4 rerun pass",   int'(pass), 1);

      // Start pulsed in R0 is ignored; start held into DONE restarts.
      run_start(8'h96);
      n = 0;
      while (busy && n < 400) begin
         start = (n == 80) || (n >= 250);
         tick();
         n++;
      end
      check("t5 busy cycles", n, 258);
      check("t5 done",        int'(done), 1);
      tick();
      start = 1'b0;
      check("t5 restart busy", int'(busy), 1);
      check("t5 restart done", int'(done), 0);
      wait_idle(n);
      check("t5 second run cycles", n, 258);
      check("t5 second run pass",   int'(pass), 1);
      tick();

      // Reset in the middle of R0 with failing reads.
      mode = 2;
      run_start(8'h55);
      repeat (70) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6 ram_addr",   int'(ram_addr),   0);
      check("t6 ram_we",     int'(ram_we),     0);
      check("t6 ram_wdata",  int'(ram_wdata),  0);
      check("t6 busy",       int'(busy),       0);
      check("t6 done",       int'(done),       0);
      check("t6 pass",       int'(pass),       0);
      check("t6 err_count",  int'(err_count),  0);
      check("t6 fail_addr",  int'(fail_addr),  0);
      check("t6 fail_phase", int'(fail_phase), 0);
      tick();
      check("t6 no late err", int'(err_count), 0);
      repeat (2) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
